// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : backward-direction stall/bubble control for the FD/DX/XM/MW latches,
//           with load-use hazard detection and the multdiv launch/wait/complete handshake.
// Latency : load-use stall is combinational on the current IRs; a mul/div costs
//           IDLE -> LAUNCH (1) -> BUSY (until md_ready) -> DONE (1) -> IDLE.
// Backpressure: the front of the pipe (PC, FD, DX) is frozen and XM is fed nops
//           for every LAUNCH/BUSY cycle; md_ready is honoured only in BUSY.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   fd_ir, dx_ir        instructions currently held in the FD and DX latches
//   md_ready/_exception/_data   multdiv completion (level-held) with its result
//   pc_we, fd_we, dx_we write enables for PC, FD and DX
//   dx_bubble, xm_bubble        load a nop into DX / XM instead of upstream data
//   ctrl_mult, ctrl_div one-cycle multdiv launch pulses
//   md_result_valid, md_result, md_exc   registered multdiv result for XM capture
//   md_timeout          sticky flag: BUSY lasted MD_TIMEOUT cycles
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_data,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        md_result_valid,
    output logic [31:0] md_result,
    output logic        md_exc,
    output logic        md_timeout
);

    localparam int              CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_cnt_inc;

    // Registered copies of the state-dependent outputs, loaded with the value
    // they must have in the state being entered.
    logic stall_q;
    logic mult_q;
    logic div_q;
    logic done_q;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_alu;

    assign fd_op  = fd_ir[31:27];
    assign fd_rd  = fd_ir[26:22];
    assign fd_rs  = fd_ir[21:17];
    assign fd_rt  = fd_ir[16:12];
    assign dx_op  = dx_ir[31:27];
    assign dx_rd  = dx_ir[26:22];
    assign dx_alu = dx_ir[6:2];

    // Fields of the IRs that no rule here depends on.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    logic dx_mul, dx_div, dx_md;
    assign dx_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
    assign dx_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
    assign dx_md  = dx_mul || dx_div;

    // Which source registers the FD instruction actually reads.
    logic fd_reads_rs, fd_reads_rt, fd_reads_rd;
    assign fd_reads_rs = (fd_op == OP_RTYPE) || (fd_op == OP_ADDI) ||
                         (fd_op == OP_LW)    || (fd_op == OP_SW);
    assign fd_reads_rt = (fd_op == OP_RTYPE);
    assign fd_reads_rd = (fd_op == OP_SW);

    // A load into $0 never produces a value, so it never creates a hazard.
    logic dx_load, load_use;
    assign dx_load  = (dx_op == OP_LW) && (dx_rd != 5'd0);
    assign load_use = (state == S_IDLE) && dx_load &&
                      ((fd_reads_rs && (fd_rs == dx_rd)) ||
                       (fd_reads_rt && (fd_rt == dx_rd)) ||
                       (fd_reads_rd && (fd_rd == dx_rd)));

    // Counter holds at CNT_MAX once reached.
    assign busy_cnt_inc = (busy_cnt == CNT_MAX) ? busy_cnt : busy_cnt + 1'b1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy_cnt   <= '0;
            md_result  <= '0;
            md_exc     <= 1'b0;
            md_timeout <= 1'b0;
            stall_q    <= 1'b0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mult_q <= 1'b0;
            div_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dx_md) begin
                        state   <= S_LAUNCH;
                        stall_q <= 1'b1;
                        mult_q  <= dx_mul;
                        div_q   <= dx_div;
                    end
                end
                S_LAUNCH: begin
                    state    <= S_BUSY;
                    busy_cnt <= '0;
                end
                S_BUSY: begin
                    busy_cnt <= busy_cnt_inc;
                    if (busy_cnt_inc == CNT_MAX) begin
                        md_timeout <= 1'b1;
                    end
                    // A late md_ready still completes, even on the timeout cycle.
                    if (md_ready) begin
                        md_result <= md_data;
                        md_exc    <= md_exception;
                        state     <= S_DONE;
                        stall_q   <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Back to IDLE without looking at dx_ir: the completed
                    // mul/div is still there and must not launch again.
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive: reset forces free-running enables; otherwise the
    // registered multdiv controls, with the load-use stall layered on top
    // (the two are mutually exclusive since load_use needs IDLE).
    // ------------------------------------------------------------------
    always_comb begin
        pc_we           = 1'b1;
        fd_we           = 1'b1;
        dx_we           = 1'b1;
        dx_bubble       = 1'b0;
        xm_bubble       = 1'b0;
        ctrl_mult       = 1'b0;
        ctrl_div        = 1'b0;
        md_result_valid = 1'b0;
        if (reset) begin
            ctrl_mult       = mult_q;
            ctrl_div        = div_q;
            md_result_valid = done_q;
            if (stall_q) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_we     = 1'b0;
                xm_bubble = 1'b1;
            end
            if (load_use) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                dx_bubble = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose : self-checking bench for pipeline_hazard_ctrl against a behavioural model.
// Latency : model advances once per rising edge; outputs checked 1 time unit after the falling edge.
// Backpressure: stimulus follows the model's view of the multdiv operation in flight.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir, md_data, md_result;
    logic        md_ready, md_exception;
    logic        pc_we, fd_we, dx_we, dx_bubble, xm_bubble;
    logic        ctrl_mult, ctrl_div, md_result_valid, md_exc, md_timeout;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40)) dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
        .md_ready(md_ready), .md_exception(md_exception), .md_data(md_data),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .dx_bubble(dx_bubble),
        .xm_bubble(xm_bubble), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .md_result_valid(md_result_valid), .md_result(md_result),
        .md_exc(md_exc), .md_timeout(md_timeout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: which phase of a multdiv operation we are in, and its results.
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_BUSY = 2, P_DONE = 3;
    int          m_phase = P_IDLE;
    bit          m_mul   = 1'b0;
    int          m_busy  = 0;
    logic [31:0] m_res   = '0;
    logic        m_exc   = 1'b0;
    logic        m_to    = 1'b0;

    // Outputs seen in the most recent step.
    logic obs_mult, obs_div, obs_dx_we, obs_valid;

    localparam logic [31:0] NOP = 32'h0000_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'd0};
    endfunction

    // 0 = not a multdiv, 1 = mul, 2 = div
    function automatic int md_kind(input logic [31:0] ir);
        if (ir[31:27] != 5'd0) return 0;
        if (ir[6:2] == 5'd6) return 1;
        if (ir[6:2] == 5'd7) return 2;
        return 0;
    endfunction

    function automatic bit m_hazard(input logic [31:0] fd, input logic [31:0] dx);
        int srcs[$];
        int op;
        if (dx[31:27] != 5'd8 || dx[26:22] == 5'd0) return 1'b0;
        op = int'(fd[31:27]);
        if (op == 0)                srcs = '{int'(fd[21:17]), int'(fd[16:12])};
        else if (op == 5 || op == 8) srcs = '{int'(fd[21:17])};
        else if (op == 7)           srcs = '{int'(fd[21:17]), int'(fd[26:22])};
        foreach (srcs[i]) if (srcs[i] == int'(dx[26:22])) return 1'b1;
        return 1'b0;
    endfunction

    // Check every output against the model, then advance one clock.
    task automatic step();
        logic e_pc, e_fd, e_dx, e_dxb, e_xmb, e_m, e_d, e_v;
        bit   hz;
        #1;
        {e_pc, e_fd, e_dx, e_dxb, e_xmb, e_m, e_d, e_v} = 8'b1110_0000;
        if (reset) begin
            case (m_phase)
                P_IDLE: begin
                    hz   = m_hazard(fd_ir, dx_ir);
                    e_pc = !hz; e_fd = !hz; e_dxb = hz;
                end
                P_LAUNCH, P_BUSY: begin
                    e_pc = 0; e_fd = 0; e_dx = 0; e_xmb = 1;
                    if (m_phase == P_LAUNCH) begin
                        e_m = m_mul; e_d = !m_mul;
                    end
                end
                default: e_v = 1;
            endcase
        end
        check("pc_we", 32'(pc_we), 32'(e_pc));
        check("fd_we", 32'(fd_we), 32'(e_fd));
        check("dx_we", 32'(dx_we), 32'(e_dx));
        check("dx_bubble", 32'(dx_bubble), 32'(e_dxb));
        check("xm_bubble", 32'(xm_bubble), 32'(e_xmb));
        check("ctrl_mult", 32'(ctrl_mult), 32'(e_m));
        check("ctrl_div", 32'(ctrl_div), 32'(e_d));
        check("md_result_valid", 32'(md_result_valid), 32'(e_v));
        check("md_result", md_result, m_res);
        check("md_exc", 32'(md_exc), 32'(m_exc));
        check("md_timeout", 32'(md_timeout), 32'(m_to));
        obs_mult = ctrl_mult; obs_div = ctrl_div; obs_dx_we = dx_we; obs_valid = md_result_valid;
        @(posedge clock);
        if (!reset) begin
            m_phase = P_IDLE; m_busy = 0; m_res = '0; m_exc = 0; m_to = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (md_kind(dx_ir) != 0) begin
                    m_phase = P_LAUNCH; m_mul = (md_kind(dx_ir) == 1);
                end
                P_LAUNCH: begin m_phase = P_BUSY; m_busy = 0; end
                P_BUSY: begin
                    m_busy++;
                    if (m_busy >= 40) m_to = 1;
                    if (md_ready) begin
                        m_res = md_data; m_exc = md_exception; m_phase = P_DONE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
        @(negedge clock);
    endtask

    // One mul/div from IDLE, with md_ready on the delay-th BUSY cycle.
    task automatic run_md(input logic [31:0] ir, input int delay,
                          input logic [31:0] data, input logic exc);
        int pulses = 0, wrong = 0, stalls = 0;
        bit is_mul = (md_kind(ir) == 1);
        dx_ir = ir; fd_ir = NOP; md_ready = 0; md_data = data; md_exception = exc;
        step();
        for (int i = 0; i <= delay; i++) begin
            md_ready = (i == delay);
            step();
            pulses += is_mul ? int'(obs_mult) : int'(obs_div);
            wrong  += is_mul ? int'(obs_div)  : int'(obs_mult);
            stalls += int'(!obs_dx_we);
        end
        step();   // DONE, mul/div still sitting in DX
        pulses += is_mul ? int'(obs_mult) : int'(obs_div);
        check("md_done_valid", 32'(obs_valid), 32'd1);
        check("md_done_result", md_result, data);
        check("md_done_exc", 32'(md_exc), 32'(exc));
        check("md_launch_pulses", 32'(pulses), 32'd1);
        check("md_other_pulses", 32'(wrong), 32'd0);
        check("md_stall_cycles", 32'(stalls), 32'(delay + 1));
        md_ready = 0;
        dx_ir = NOP;
    endtask

    function automatic logic [31:0] rand_ir(input bit allow_md);
        logic [4:0] r1, r2, r3;
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        r3 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, allow_md ? 7 : 5))
            0: return mk(5'd0, r1, r2, r3, 5'd0);
            1: return mk(5'd5, r1, r2, r3, 5'($urandom));
            2: return mk(5'd7, r1, r2, r3, 5'($urandom));
            3, 4: return mk(5'd8, r1, r2, r3, 5'($urandom));
            5: return mk(5'($urandom_range(1, 31)), r1, r2, r3, 5'($urandom));
            6: return mk(5'd0, r1, r2, r3, 5'd6);
            default: return mk(5'd0, r1, r2, r3, 5'd7);
        endcase
    endfunction

    initial begin
        int target;
        reset = 0; fd_ir = NOP; dx_ir = NOP;
        md_ready = 0; md_exception = 0; md_data = '0;
        @(negedge clock);
        step(); step();
        reset = 1;
        step(); step();

        // Load-use on rs of an add; then the bubble has gone through.
        dx_ir = 32'h40C2_0000; fd_ir = 32'h0106_2000;
        #1;
        check("lu_pc_we", 32'(pc_we), 32'd0);
        check("lu_dx_bubble", 32'(dx_bubble), 32'd1);
        step();
        dx_ir = NOP;
        step();
        // lw into $0 never stalls.
        dx_ir = 32'h4002_0000; fd_ir = 32'h0100_2000;
        #1;
        check("lu_rd0_bubble", 32'(dx_bubble), 32'd0);
        step();
        // md_ready outside BUSY is ignored.
        dx_ir = NOP; md_ready = 1; md_data = 32'hDEAD_BEEF; md_exception = 1;
        step(); step();
        md_ready = 0;

        run_md(32'h0142_2018, 17, 32'h0000_002A, 1'b0);
        step();
        run_md(mk(5'd0, 5'd6, 5'd1, 5'd2, 5'd7), 5, 32'h1234_5678, 1'b1);
        // Back-to-back mul, straight after DONE.
        run_md(32'h0142_2018, 3, 32'h0000_0011, 1'b0);
        run_md(32'h0142_2018, 1, 32'h0000_0022, 1'b0);
        step();

        // Randomised traffic, occasional reset.
        target = 1;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 149) != 0);
            if (m_phase == P_IDLE) begin
                dx_ir = rand_ir(1'b1);
                fd_ir = rand_ir(1'b0);
                md_ready = 1'($urandom);
                md_data = $urandom;
                md_exception = 1'($urandom);
                target = $urandom_range(1, 30);
            end else if (m_phase == P_BUSY) begin
                md_ready = (m_busy + 1 >= target);
            end else if (m_phase == P_LAUNCH) begin
                md_ready = 0;
            end
            if (m_phase != P_IDLE) fd_ir = rand_ir(1'b0);
            step();
        end
        reset = 1;
        for (int c = 0; c < 60 && m_phase != P_IDLE; c++) begin
            md_ready = (m_phase == P_BUSY);
            step();
        end
        check("drain_idle", 32'(m_phase), 32'(P_IDLE));
        md_ready = 0; dx_ir = NOP;
        step();

        // Timeout: md_ready never comes.
        dx_ir = 32'h0142_2018; fd_ir = NOP;
        step(); step();
        for (int i = 0; i < 45; i++) begin
            if (i == 39) begin
                #1;
                check("to_before_40", 32'(md_timeout), 32'd0);
            end
            step();
        end
        #1;
        check("to_sticky", 32'(md_timeout), 32'd1);
        check("to_still_stalled", 32'(dx_we), 32'd0);
        // Reset mid-BUSY abandons the operation.
        reset = 0;
        step(); step();
        reset = 1; dx_ir = NOP;
        #1;
        check("rst_valid", 32'(md_result_valid), 32'd0);
        check("rst_result", md_result, 32'd0);
        check("rst_timeout", 32'(md_timeout), 32'd0);
        check("rst_dx_we", 32'(dx_we), 32'd1);
        md_ready = 1;
        step(); step();
        md_ready = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
